// File: rtl/pe_array_pkg.sv
// rtl/pe_array_pkg.sv - shared FSM encoding, default sizes and width helper
package pe_array_pkg;

  localparam int N_DEF         = 4;
  localparam int DEPTH_DEF     = 16;
  localparam int RES_DEPTH_DEF = 16;
  localparam int TIMEOUT_DEF   = 255;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD_X,
    ST_LOAD_Y,
    ST_LOAD_Z,
    ST_START,
    ST_RUN,
    ST_NEXT,
    ST_FIN,
    ST_ERR
  } state_e;

  // Index width for a memory of n entries; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int VEC_AW_DEF = addr_w(DEPTH_DEF);
  localparam int RES_AW_DEF = addr_w(RES_DEPTH_DEF);

endpackage

// File: rtl/pe_done_tracker.sv
// rtl/pe_done_tracker.sv - sticky per-PE completion mask plus RUN watchdog
module pe_done_tracker
  import pe_array_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         run_i,
  input  logic [N-1:0] pe_done_i,
  output logic         all_done_o,
  output logic         timeout_o
);

  localparam int WDW = addr_w(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  logic [N-1:0]   mask_q, mask_d;
  logic [WDW-1:0] wd_q, wd_d;

  always_comb begin
    mask_d = mask_q;
    wd_d   = wd_q;
    if (clear_i) begin
      mask_d = '0;
      wd_d   = '0;
    end else if (run_i) begin
      mask_d = mask_q | pe_done_i;
      wd_d   = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q <= '0;
      wd_q   <= '0;
    end else begin
      mask_q <= mask_d;
      wd_q   <= wd_d;
    end
  end

  // wd_q counts finished RUN cycles, so the TIMEOUT-th cycle sees TIMEOUT-1.
  assign all_done_o = run_i & (&(mask_q | pe_done_i));
  assign timeout_o  = run_i & (wd_q == WD_LAST) & ~all_done_o;

endmodule

// File: rtl/pe_array_sequencer.sv
// rtl/pe_array_sequencer.sv - sequences PE clear/load/start/run per vector, passes and results
module pe_array_sequencer
  import pe_array_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int RES_DEPTH = RES_DEPTH_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode,
  input  logic                         stop,
  input  logic [N-1:0]                 peDoneIn,
  input  logic                         storeToMemIn,
  output logic [N-1:0]                 peRstOut,
  output logic                         peStartOut,
  output logic                         xEnOut,
  output logic                         yEnOut,
  output logic                         zEnOut,
  output logic [addr_w(DEPTH)-1:0]     dataMemAddrOut,
  output logic                         dataMemAddrSelOut,
  output logic                         resMemWrEnOut,
  output logic [addr_w(RES_DEPTH)-1:0] resMemAddrOut,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int VAW = addr_w(DEPTH);
  localparam int RAW = addr_w(RES_DEPTH);
  localparam logic [VAW-1:0] VEC_LAST = VAW'(DEPTH - 1);
  localparam logic [RAW-1:0] RES_LAST = RAW'(RES_DEPTH - 1);

  state_e         state_q, state_d;
  logic [VAW-1:0] vec_q, vec_d;
  logic [RAW-1:0] res_addr_q, res_addr_d;
  logic           mode_q, mode_d;
  logic           stop_q, stop_d;
  logic           error_q, error_d;
  logic           all_done, timeout, wr_en, last_vec;

  pe_done_tracker #(
    .N       (N),
    .TIMEOUT (TIMEOUT)
  ) u_tracker (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (state_q == ST_CLEAR),
    .run_i      (state_q == ST_RUN),
    .pe_done_i  (peDoneIn),
    .all_done_o (all_done),
    .timeout_o  (timeout)
  );

  assign wr_en    = ((state_q == ST_RUN) || (state_q == ST_NEXT)) && storeToMemIn;
  assign last_vec = stop_q || (vec_q == VEC_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_LOAD_X;
      ST_LOAD_X: state_d = ST_LOAD_Y;
      ST_LOAD_Y: state_d = ST_LOAD_Z;
      ST_LOAD_Z: state_d = ST_START;
      ST_START:  state_d = ST_RUN;
      ST_RUN: begin
        if (all_done)     state_d = ST_NEXT;
        else if (timeout) state_d = ST_ERR;
      end
      ST_NEXT:   state_d = last_vec ? ST_FIN : ST_CLEAR;
      ST_FIN:    state_d = (mode_q && !stop_q) ? ST_CLEAR : ST_IDLE;
      ST_ERR:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vec_d      = vec_q;
    res_addr_d = res_addr_q;
    mode_d     = mode_q;
    stop_d     = stop_q;
    error_d    = error_q;
    if (wr_en) res_addr_d = (res_addr_q == RES_LAST) ? '0 : res_addr_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        if (start) begin
          mode_d     = mode;
          vec_d      = '0;
          error_d    = 1'b0;
          res_addr_d = '0;
        end
      end
      ST_NEXT: if (!last_vec) vec_d = vec_q + 1'b1;
      ST_FIN:  if (mode_q && !stop_q) vec_d = '0;
      ST_ERR:  error_d = 1'b1;
      default: ;
    endcase
    // A stop request lingers until the pass ends, so a short pulse is never lost.
    if (state_q != ST_IDLE && stop) stop_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q      <= '0;
      res_addr_q <= '0;
      mode_q     <= 1'b0;
      stop_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      vec_q      <= vec_d;
      res_addr_q <= res_addr_d;
      mode_q     <= mode_d;
      stop_q     <= stop_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    peRstOut          = '0;
    peStartOut        = 1'b0;
    xEnOut            = 1'b0;
    yEnOut            = 1'b0;
    zEnOut            = 1'b0;
    dataMemAddrOut    = '0;
    dataMemAddrSelOut = 1'b0;
    resMemWrEnOut     = 1'b0;
    resMemAddrOut     = '0;
    busy              = 1'b0;
    done              = 1'b0;
    error             = 1'b0;
    if (rst) begin
      peRstOut = '1;
    end else begin
      case (state_q)
        ST_CLEAR, ST_ERR: peRstOut = '1;
        ST_LOAD_X: begin
          xEnOut         = 1'b1;
          dataMemAddrOut = vec_q;
        end
        ST_LOAD_Y: begin
          yEnOut         = 1'b1;
          dataMemAddrOut = vec_q;
        end
        ST_LOAD_Z: begin
          zEnOut            = 1'b1;
          dataMemAddrOut    = vec_q;
          dataMemAddrSelOut = 1'b1;
        end
        ST_START: peStartOut = 1'b1;
        ST_FIN:   done       = 1'b1;
        default: ;
      endcase
      resMemWrEnOut = wr_en;
      resMemAddrOut = res_addr_q;
      busy          = (state_q != ST_IDLE);
      error         = error_q;
    end
  end

endmodule
